// File: rtl/stream_bit_reducer_pkg.sv
// stream_bit_reducer_pkg: state encoding, OPERATION decode and counter saturation limit
package stream_bit_reducer_pkg;
  typedef enum logic {S_FIRST, S_ACCUM} state_t;
  typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR} op_t;
  function automatic logic op_supported(input string op);
    return op == "AND" || op == "NAND" || op == "OR" || op == "NOR" || op == "XOR" || op == "XNOR";
  endfunction
  function automatic op_t base_of(input string op);
    return (op == "AND" || op == "NAND") ? OP_AND : (op == "OR" || op == "NOR") ? OP_OR : OP_XOR;
  endfunction
  function automatic logic is_inverted(input string op);
    return op == "NAND" || op == "NOR" || op == "XNOR";
  endfunction
  function automatic logic combine(input op_t op, input logic a, input logic b);
    return op == OP_AND ? a & b : op == OP_OR ? a | b : a ^ b;
  endfunction
  function automatic longint unsigned sat_max(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction
endpackage

// File: rtl/stream_bit_reducer_bit_reducer.sv
// Bit_Reducer: collapses INPUT_COUNT bits to one bit with the selected base operation
module Bit_Reducer
  import stream_bit_reducer_pkg::*;
#(
  parameter op_t OPERATION = OP_XOR,
  parameter int INPUT_COUNT = 8
) (
  input  logic [INPUT_COUNT-1:0] in_bits,
  output logic                   out_bit
);
  always_comb out_bit = OPERATION == OP_AND ? &in_bits : OPERATION == OP_OR ? |in_bits : ^in_bits;
endmodule

// File: rtl/stream_bit_reducer.sv
// stream_bit_reducer: reduces each frame of beats to one bit; per-frame beat count
// is present when STREAM_BIT_REDUCER_BEAT_COUNT_EN is defined.
module stream_bit_reducer
  import stream_bit_reducer_pkg::*;
#(
  parameter string OPERATION   = "XOR",
  parameter int    WORD_WIDTH  = 8,
  parameter int    COUNT_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_bit
`ifdef STREAM_BIT_REDUCER_BEAT_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0] out_beats
`endif
);
  localparam op_t  BASE = base_of(OPERATION);
  localparam logic INV  = is_inverted(OPERATION);

  if (!op_supported(OPERATION) || WORD_WIDTH < 1 || COUNT_WIDTH < 1) begin : g_bad_cfg
    $error("stream_bit_reducer: unsupported OPERATION or width");
  end

  state_t state_q;
  logic   acc_q, acc_d, out_valid_q, out_bit_q, beat_bit, in_fire, first;

  Bit_Reducer #(.OPERATION(BASE), .INPUT_COUNT(WORD_WIDTH)) u_reduce (
    .in_bits(in_data),
    .out_bit(beat_bit)
  );

  assign in_ready  = ~out_valid_q | out_ready;
  assign in_fire   = in_valid & in_ready;
  assign first     = state_q == S_FIRST;
  assign acc_d     = first ? beat_bit : combine(BASE, acc_q, beat_bit);
  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;

`ifdef STREAM_BIT_REDUCER_BEAT_COUNT_EN
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = COUNT_WIDTH'(sat_max(COUNT_WIDTH));
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, out_beats_q;
  assign cnt_d     = first ? COUNT_WIDTH'(1) : (cnt_q == CNT_MAX ? cnt_q : cnt_q + 1'b1);
  assign out_beats = out_beats_q;
`endif

  always_ff @(posedge clock or negedge clear_n)
    if (!clear_n) begin
      state_q     <= S_FIRST;
      acc_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
`ifdef STREAM_BIT_REDUCER_BEAT_COUNT_EN
      cnt_q       <= '0;
      out_beats_q <= '0;
`endif
    end else begin
      if (in_fire) begin
        acc_q   <= acc_d;
        state_q <= in_last ? S_FIRST : S_ACCUM;
`ifdef STREAM_BIT_REDUCER_BEAT_COUNT_EN
        cnt_q   <= cnt_d;
`endif
      end
      // a new result may replace the one being consumed in the same cycle
      if (in_fire && in_last) begin
        out_valid_q <= 1'b1;
        out_bit_q   <= acc_d ^ INV;
`ifdef STREAM_BIT_REDUCER_BEAT_COUNT_EN
        out_beats_q <= cnt_d;
`endif
      end else if (out_ready) out_valid_q <= 1'b0;
    end
endmodule

// File: tb/tb_stream_bit_reducer.sv
// tb_stream_bit_reducer: XOR/W8, NAND/W4/CW2 and OR/W8 instances share one input stream
// and are checked against a frame-level reference model.
module tb_stream_bit_reducer;
  logic clock = 1'b0, clear_n = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = '0;
  logic rdy_x, rdy_n, rdy_o, val_x, val_n, val_o, bit_x, bit_n, bit_o;
`ifdef STREAM_BIT_REDUCER_BEAT_COUNT_EN
  logic [7:0] beats_x, beats_o;
  logic [1:0] beats_n;
  int exp_c8, exp_c2;
`endif
  int errors = 0, checks = 0;
  logic [7:0] q[$];
  bit exp_v = 1'b0, ex_x, ex_n, ex_o;

  always #5 clock = ~clock;

  stream_bit_reducer #(.OPERATION("XOR"), .WORD_WIDTH(8), .COUNT_WIDTH(8)) u_x (
    .clock(clock), .clear_n(clear_n), .in_valid(in_valid), .in_ready(rdy_x), .in_data(in_data),
    .in_last(in_last), .out_valid(val_x), .out_ready(out_ready), .out_bit(bit_x)
`ifdef STREAM_BIT_REDUCER_BEAT_COUNT_EN
    , .out_beats(beats_x)
`endif
  );
  stream_bit_reducer #(.OPERATION("NAND"), .WORD_WIDTH(4), .COUNT_WIDTH(2)) u_n (
    .clock(clock), .clear_n(clear_n), .in_valid(in_valid), .in_ready(rdy_n), .in_data(in_data[3:0]),
    .in_last(in_last), .out_valid(val_n), .out_ready(out_ready), .out_bit(bit_n)
`ifdef STREAM_BIT_REDUCER_BEAT_COUNT_EN
    , .out_beats(beats_n)
`endif
  );
  stream_bit_reducer #(.OPERATION("OR"), .WORD_WIDTH(8), .COUNT_WIDTH(8)) u_o (
    .clock(clock), .clear_n(clear_n), .in_valid(in_valid), .in_ready(rdy_o), .in_data(in_data),
    .in_last(in_last), .out_valid(val_o), .out_ready(out_ready), .out_bit(bit_o)
`ifdef STREAM_BIT_REDUCER_BEAT_COUNT_EN
    , .out_beats(beats_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // frame results from the whole frame at once: parity, any-bit, all-ones
  function automatic void model_frame();
    bit p = 1'b0, any = 1'b0, all = 1'b1;
    foreach (q[i]) begin
      p   ^= ^q[i];
      any |= q[i] != 8'h00;
      all &= q[i][3:0] == 4'hF;
    end
    ex_x = p;
    ex_o = any;
    ex_n = !all;
`ifdef STREAM_BIT_REDUCER_BEAT_COUNT_EN
    exp_c8 = q.size() > 255 ? 255 : q.size();
    exp_c2 = q.size() > 3 ? 3 : q.size();
`endif
    q.delete();
  endfunction

  task automatic check_out();
    chk("x_valid", val_x, exp_v);
    chk("n_valid", val_n, exp_v);
    chk("o_valid", val_o, exp_v);
    if (exp_v) begin
      chk("x_bit", bit_x, ex_x);
      chk("n_bit", bit_n, ex_n);
      chk("o_bit", bit_o, ex_o);
`ifdef STREAM_BIT_REDUCER_BEAT_COUNT_EN
      chk("x_beats", beats_x, exp_c8);
      chk("n_beats", beats_n, exp_c2);
      chk("o_beats", beats_o, exp_c8);
`endif
    end
  endtask

  task automatic cycle(input bit v, input logic [7:0] d, input bit l, input bit ro);
    bit fire;
    in_valid = v; in_data = d; in_last = l; out_ready = ro;
    #1;
    chk("x_in_ready", rdy_x, !exp_v || ro);
    chk("n_in_ready", rdy_n, !exp_v || ro);
    chk("o_in_ready", rdy_o, !exp_v || ro);
    fire = v && (!exp_v || ro);
    @(posedge clock);
    if (fire) q.push_back(d);
    if (fire && l) begin
      model_frame();
      exp_v = 1'b1;
    end else if (ro) exp_v = 1'b0;
    @(negedge clock);
    check_out();
  endtask

  initial begin
    #2;
    chk("rst_x_valid", val_x, 0);
    chk("rst_x_bit", bit_x, 0);
    chk("rst_n_bit", bit_n, 0);
    chk("rst_x_ready", rdy_x, 1);
    @(negedge clock);
    clear_n = 1'b1;
    // two-beat XOR frame: parity(0x01)^parity(0x03) = 1
    cycle(1, 8'h01, 0, 1);
    cycle(1, 8'h03, 1, 1);
    chk("xor_two_beat", bit_x, 1);
`ifdef STREAM_BIT_REDUCER_BEAT_COUNT_EN
    chk("xor_two_beat_cnt", beats_x, 2);
`endif
    cycle(1, 8'h0F, 1, 1);
    chk("nand_all_ones", bit_n, 0);
    cycle(1, 8'h07, 1, 1);
    chk("nand_not_all", bit_n, 1);
    // result held for 5 cycles while the consumer stalls
    cycle(1, 8'h10, 1, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 8'($urandom), 1, 0);
      chk("or_hold_bit", bit_o, 1);
      chk("or_hold_ready", rdy_o, 0);
    end
    cycle(0, 8'h00, 0, 1);
    for (int i = 0; i < 8; i++) begin
      cycle(1, 8'($urandom), 1, 1);
      chk("b2b_valid", val_x, 1);
    end
    for (int i = 0; i < 5; i++) cycle(1, 8'h0F, 0, 1);
    cycle(1, 8'h0F, 1, 1);
    chk("six_beat_nand", bit_n, 0);
`ifdef STREAM_BIT_REDUCER_BEAT_COUNT_EN
    chk("six_beat_sat", beats_n, 3);
    chk("six_beat_x", beats_x, 6);
`endif
    // stale result bits at 1, then three beats discarded by reset
    cycle(1, 8'h01, 1, 1);
    for (int i = 0; i < 3; i++) cycle(1, 8'h01, 0, 1);
    #2 clear_n = 1'b0;
    #1;
    chk("clr_x_valid", val_x, 0);
    chk("clr_x_bit", bit_x, 0);
    chk("clr_o_bit", bit_o, 0);
    chk("clr_n_bit", bit_n, 0);
`ifdef STREAM_BIT_REDUCER_BEAT_COUNT_EN
    chk("clr_x_beats", beats_x, 0);
`endif
    q.delete();
    exp_v = 1'b0;
    clear_n = 1'b1;
    cycle(1, 8'h03, 1, 1);
    chk("after_clr_xor", bit_x, 0);
`ifdef STREAM_BIT_REDUCER_BEAT_COUNT_EN
    chk("after_clr_cnt", beats_x, 1);
`endif
    for (int i = 0; i < 400; i++) begin
      logic [7:0] d;
      d = ($urandom % 3 == 0) ? 8'h0F : 8'($urandom);
      cycle($urandom % 4 != 0, d, $urandom % 3 == 0, $urandom % 4 != 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
